// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one external memory bus among N_REQ requesters.
// A grant is held until the external done strobe or a timeout; a RELEASE
// cycle follows every transaction, and a requester may keep its grant across
// transactions (lock) to perform read-modify-write sequences.
module mem_bus_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_read,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ-1:0]          req_lock,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic                      err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      read_q,
  output logic                      write_q,
  output logic [ADDR_W-1:0]         addr_out,
  output logic [DATA_W-1:0]         data_out,
  input  logic                      read_dn,
  input  logic                      write_dn,
  input  logic [DATA_W-1:0]         data_in,
  output logic                      bus_busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

  state_t             state, state_d;
  logic [N_REQ-1:0]   gnt_d, done_d;
  logic               err_d, read_q_d, write_q_d, bus_busy_d;
  logic [DATA_W-1:0]  rdata_d;
  logic               is_write, is_write_d;
  logic [IDX_W-1:0]   owner, owner_d;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
  logic               locked, locked_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               load;
  logic [ADDR_W-1:0]  addr_lat;
  logic [DATA_W-1:0]  data_lat;

  // Arbitration: rotate the active vector so rr_ptr lands at bit 0, then
  // take the lowest set bit and rotate the offset back to an index.
  logic [N_REQ-1:0]   active;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic               win_found;
  logic [IDX_W-1:0]   win_off, win_idx, sel_idx;
  logic [IDX_W:0]     win_sum;
  logic               expire;

  assign active    = req_read | req_write;
  assign dbl       = {active, active} >> rr_ptr;
  assign rot       = dbl[N_REQ-1:0];
  assign win_found = |rot;
  assign win_sum   = {1'b0, rr_ptr} + {1'b0, win_off};
  assign win_idx   = (win_sum >= (IDX_W+1)'(N_REQ)) ?
                     IDX_W'(win_sum - (IDX_W+1)'(N_REQ)) : win_sum[IDX_W-1:0];
  assign sel_idx   = locked ? owner : win_idx;
  assign expire    = (TIMEOUT != 0) && ((32'(cnt) + 32'd1) == 32'(TIMEOUT));

  // Lowest set bit of the rotated request vector (offset from rr_ptr).
  always_comb begin
    win_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) win_off = IDX_W'(i);
    end
  end

  // Per-requester muxes: the slice being granted, and the current owner's lines.
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_write, own_active, own_lock;

  // Select the winner's address/data/op and the owner's lock/request lines.
  always_comb begin
    sel_addr   = '0;
    sel_data   = '0;
    sel_write  = 1'b0;
    own_active = 1'b0;
    own_lock   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == sel_idx) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_data  = req_data[i*DATA_W +: DATA_W];
        sel_write = req_write[i];
      end
      if (IDX_W'(i) == owner) begin
        own_active = req_read[i] | req_write[i];
        own_lock   = req_lock[i];
      end
    end
  end

  // Next-state and next-output logic for the IDLE/BUSY/RELEASE controller.
  always_comb begin
    state_d    = state;
    gnt_d      = gnt;
    done_d     = '0;
    err_d      = 1'b0;
    rdata_d    = rdata;
    read_q_d   = read_q;
    write_q_d  = write_q;
    is_write_d = is_write;
    owner_d    = owner;
    rr_ptr_d   = rr_ptr;
    locked_d   = locked;
    cnt_d      = cnt;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        if (locked) begin
          // Only the lock owner is eligible; the pointer stays where it is.
          if (own_active) begin
            load = 1'b1;
          end else if (!own_lock) begin
            locked_d = 1'b0;
            gnt_d    = '0;
          end
        end else if (win_found) begin
          load     = 1'b1;
          gnt_d    = N_REQ'(1) << win_idx;
          owner_d  = win_idx;
          rr_ptr_d = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end
        if (load) begin
          state_d    = S_BUSY;
          is_write_d = sel_write;
          read_q_d   = ~sel_write;
          write_q_d  = sel_write;
          cnt_d      = '0;
        end
      end
      S_BUSY: begin
        // A done strobe wins over a simultaneous expiry.
        if (is_write ? write_dn : read_dn) begin
          read_q_d  = 1'b0;
          write_q_d = 1'b0;
          done_d    = gnt;
          state_d   = S_RELEASE;
          if (!is_write) rdata_d = data_in;
        end else if (expire) begin
          read_q_d  = 1'b0;
          write_q_d = 1'b0;
          done_d    = gnt;
          err_d     = 1'b1;
          state_d   = S_RELEASE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        // No arbitration here, so level requests left over from the
        // finished transaction cannot win a second grant.
        if (own_lock) begin
          locked_d = 1'b1;
        end else begin
          locked_d = 1'b0;
          gnt_d    = '0;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    bus_busy_d = (state_d != S_IDLE);
  end

  // Control and output registers; reset aborts any transaction silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      gnt      <= '0;
      done     <= '0;
      err      <= 1'b0;
      rdata    <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      bus_busy <= 1'b0;
      is_write <= 1'b0;
      owner    <= '0;
      rr_ptr   <= '0;
      locked   <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      done     <= done_d;
      err      <= err_d;
      rdata    <= rdata_d;
      read_q   <= read_q_d;
      write_q  <= write_q_d;
      bus_busy <= bus_busy_d;
      is_write <= is_write_d;
      owner    <= owner_d;
      rr_ptr   <= rr_ptr_d;
      locked   <= locked_d;
      cnt      <= cnt_d;
    end
  end

  // Address/data captured from the winner at grant time.
  always_ff @(posedge clk) begin
    if (load) begin
      addr_lat <= sel_addr;
      data_lat <= sel_data;
    end
  end

  // Bus outputs are ORed with other masters, so they must be 0 when idle.
  assign addr_out = (read_q | write_q) ? addr_lat : '0;
  assign data_out = write_q ? data_lat : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a
// randomized run compared against a transaction-level round-robin model.
module tb_mem_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_read = '0, req_write = '0, req_lock = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    gnt, done;
  logic            err, read_q, write_q, bus_busy;
  logic [DW-1:0]   rdata, data_out;
  logic [AW-1:0]   addr_out;
  logic            read_dn = 1'b0, write_dn = 1'b0;
  logic [DW-1:0]   data_in = '0;

  int checks   = 0;
  int failures = 0;
  int m_rr     = 0;          // model round-robin pointer
  logic [DW-1:0] m_rdata = '0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_lock(req_lock), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .read_q(read_q),
    .write_q(write_q), .addr_out(addr_out), .data_out(data_out),
    .read_dn(read_dn), .write_dn(write_dn), .data_in(data_in),
    .bus_busy(bus_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic rd, input logic wr, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_read[i]  = rd;
    req_write[i] = wr;
    req_lock[i]  = lk;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    req_read = '0; req_write = '0; req_lock = '0;
    read_dn = 1'b0; write_dn = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    m_rr = 0;
    m_rdata = '0;
  endtask

  task automatic test_reset();
    #3;
    req_read[0] = 1'b1;
    rst = 1'b0;
    #1;
    checks++;
    if ({gnt, done, err, read_q, write_q, bus_busy} !== '0 || addr_out !== '0 ||
        data_out !== '0 || rdata !== '0) begin
      failures++;
      $display("FAIL reset_outputs: gnt=%b done=%b err=%b rq=%b wq=%b busy=%b addr=%h data=%h rdata=%h, required all 0",
               gnt, done, err, read_q, write_q, bus_busy, addr_out, data_out, rdata);
    end
    tick();
    checks++;
    if (gnt !== '0 || read_q !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: gnt=%b read_q=%b, required 0000/0", gnt, read_q);
    end
    req_read[0] = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (gnt !== '0 || bus_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: gnt=%b busy=%b, required 0000/0", gnt, bus_busy);
    end
  endtask

  task automatic test_single_read();
    apply_reset();
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    tick();
    req_read[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({gnt, read_q, write_q, bus_busy, done} !== {4'b0010, 1'b1, 1'b0, 1'b1, 4'b0000} ||
          addr_out !== 32'h100) begin
        failures++;
        $display("FAIL single_read_busy[%0d]: gnt=%b rq=%b wq=%b busy=%b done=%b addr=%h, required 0010/1/0/1/0000/100",
                 c, gnt, read_q, write_q, bus_busy, done, addr_out);
      end
      if (c == 2) begin
        read_dn = 1'b1;
        data_in = 32'hDEADBEEF;
      end
      tick();
    end
    read_dn = 1'b0;
    checks++;
    if ({read_q, done, err} !== {1'b0, 4'b0010, 1'b0} || rdata !== 32'hDEADBEEF ||
        addr_out !== '0) begin
      failures++;
      $display("FAIL single_read_done: rq=%b done=%b err=%b rdata=%h addr=%h, required 0/0010/0/deadbeef/0",
               read_q, done, err, rdata, addr_out);
    end
    tick();
    checks++;
    if ({gnt, done, bus_busy} !== '0 || rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_read_release: gnt=%b done=%b busy=%b rdata=%h, required 0/0/0/deadbeef",
               gnt, done, busy_fmt(bus_busy), rdata);
    end
  endtask

  function automatic logic busy_fmt(input logic b);
    return b;
  endfunction

  task automatic test_contention();
    apply_reset();
    set_req(0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h11112222);
    set_req(2, 1'b1, 1'b0, 1'b0, 32'h80, 32'h0);
    tick();
    req_write[0] = 1'b0;
    checks++;
    if ({gnt, read_q, write_q} !== {4'b0001, 1'b0, 1'b1} || addr_out !== 32'h40 ||
        data_out !== 32'h11112222) begin
      failures++;
      $display("FAIL contention_first: gnt=%b rq=%b wq=%b addr=%h data=%h, required 0001/0/1/40/11112222",
               gnt, read_q, write_q, addr_out, data_out);
    end
    read_dn = 1'b1;          // opposite-op done must be ignored
    tick();
    read_dn = 1'b0;
    checks++;
    if (write_q !== 1'b1 || done !== '0) begin
      failures++;
      $display("FAIL contention_wrong_dn: wq=%b done=%b, required 1/0000", write_q, done);
    end
    write_dn = 1'b1;
    tick();
    write_dn = 1'b0;
    checks++;
    if ({write_q, done, err} !== {1'b0, 4'b0001, 1'b0} || rdata !== '0 || data_out !== '0) begin
      failures++;
      $display("FAIL contention_write_done: wq=%b done=%b err=%b rdata=%h data=%h, required 0/0001/0/0/0",
               write_q, done, err, rdata, data_out);
    end
    tick();
    tick();
    checks++;
    if ({gnt, read_q} !== {4'b0100, 1'b1} || addr_out !== 32'h80 || data_out !== '0) begin
      failures++;
      $display("FAIL contention_second: gnt=%b rq=%b addr=%h data=%h, required 0100/1/80/0",
               gnt, read_q, addr_out, data_out);
    end
    req_read[2] = 1'b0;
    read_dn = 1'b1;
    data_in = 32'h12345678;
    tick();
    read_dn = 1'b0;
    checks++;
    if (done !== 4'b0100 || rdata !== 32'h12345678) begin
      failures++;
      $display("FAIL contention_read_done: done=%b rdata=%h, required 0100/12345678", done, rdata);
    end
    tick();
    // Pointer should now sit at 3: requester 3 beats requester 0.
    set_req(0, 1'b1, 1'b0, 1'b0, 32'hA0, 32'h0);
    set_req(3, 1'b1, 1'b0, 1'b0, 32'hB0, 32'h0);
    tick();
    checks++;
    if (gnt !== 4'b1000 || addr_out !== 32'hB0) begin
      failures++;
      $display("FAIL contention_rr_ptr: gnt=%b addr=%h, required 1000/b0", gnt, addr_out);
    end
    req_read = '0;
    read_dn = 1'b1;
    tick();
    read_dn = 1'b0;
    tick();
  endtask

  task automatic test_fairness();
    int last;
    logic [N-1:0] eg;
    apply_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b0, 32'h1000 + 32'(i), 32'h0);
    last = -1;
    for (int g = 0; g < 5; g++) begin
      tick();
      eg = '0;
      eg[g % N] = 1'b1;
      checks++;
      if (gnt !== eg || addr_out !== 32'h1000 + 32'(g % N) ||
          (last >= 0 && cyc - last != 3)) begin
        failures++;
        $display("FAIL fairness_grant[%0d]: gnt=%b addr=%h spacing=%0d, required %b/%h/3",
                 g, gnt, addr_out, cyc - last, eg, 32'h1000 + 32'(g % N));
      end
      last = cyc;
      read_dn = 1'b1;
      tick();
      read_dn = 1'b0;
      tick();
    end
    req_read = '0;
  endtask

  task automatic test_lock();
    apply_reset();
    set_req(3, 1'b1, 1'b0, 1'b1, 32'h300, 32'h0);
    tick();
    set_req(3, 1'b0, 1'b0, 1'b1, 32'h300, 32'h0);
    checks++;
    if ({gnt, read_q} !== {4'b1000, 1'b1} || addr_out !== 32'h300) begin
      failures++;
      $display("FAIL lock_first_grant: gnt=%b rq=%b addr=%h, required 1000/1/300", gnt, read_q, addr_out);
    end
    set_req(0, 1'b1, 1'b0, 1'b0, 32'hA0, 32'h0);
    read_dn = 1'b1;
    data_in = 32'hAAAA0003;
    tick();
    read_dn = 1'b0;
    checks++;
    if (done !== 4'b1000 || rdata !== 32'hAAAA0003 || gnt !== 4'b1000) begin
      failures++;
      $display("FAIL lock_read_done: done=%b rdata=%h gnt=%b, required 1000/aaaa0003/1000", done, rdata, gnt);
    end
    tick();
    checks++;
    if (gnt !== 4'b1000 || bus_busy !== 1'b0) begin
      failures++;
      $display("FAIL lock_held_release: gnt=%b busy=%b, required 1000/0", gnt, bus_busy);
    end
    set_req(3, 1'b0, 1'b1, 1'b1, 32'h304, 32'hBBBB0003);
    tick();
    set_req(3, 1'b0, 1'b0, 1'b1, 32'h304, 32'hBBBB0003);
    checks++;
    if ({gnt, write_q} !== {4'b1000, 1'b1} || addr_out !== 32'h304 || data_out !== 32'hBBBB0003) begin
      failures++;
      $display("FAIL lock_write_grant: gnt=%b wq=%b addr=%h data=%h, required 1000/1/304/bbbb0003",
               gnt, write_q, addr_out, data_out);
    end
    write_dn = 1'b1;
    tick();
    write_dn = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (gnt !== 4'b1000 || read_q !== 1'b0 || write_q !== 1'b0) begin
        failures++;
        $display("FAIL lock_blocks_other[%0d]: gnt=%b rq=%b wq=%b, required 1000/0/0", c, gnt, read_q, write_q);
      end
      tick();
    end
    req_lock[3] = 1'b0;
    tick();
    checks++;
    if (gnt !== '0 || read_q !== 1'b0) begin
      failures++;
      $display("FAIL lock_release: gnt=%b rq=%b, required 0000/0", gnt, read_q);
    end
    tick();
    checks++;
    if ({gnt, read_q} !== {4'b0001, 1'b1} || addr_out !== 32'hA0) begin
      failures++;
      $display("FAIL lock_next_owner: gnt=%b rq=%b addr=%h, required 0001/1/a0", gnt, read_q, addr_out);
    end
    req_read = '0;
    read_dn = 1'b1;
    tick();
    read_dn = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int high;
    apply_reset();
    set_req(2, 1'b0, 1'b1, 1'b0, 32'h2000, 32'h5555AAAA);
    tick();
    req_write = '0;
    high = 0;
    for (int c = 0; c < TO + 2; c++) begin
      if (write_q === 1'b1) high++;
      if (c == TO) begin
        checks++;
        if ({write_q, done, err} !== {1'b0, 4'b0100, 1'b1} || addr_out !== '0 ||
            data_out !== '0 || rdata !== m_rdata) begin
          failures++;
          $display("FAIL timeout_expiry: wq=%b done=%b err=%b addr=%h data=%h rdata=%h, required 0/0100/1/0/0/%h",
                   write_q, done, err, addr_out, data_out, rdata, m_rdata);
        end
      end
      if (c == TO + 1) begin
        checks++;
        if ({gnt, done, err, bus_busy} !== '0) begin
          failures++;
          $display("FAIL timeout_release: gnt=%b done=%b err=%b busy=%b, required 0", gnt, done, err, bus_busy);
        end
      end
      if (c < TO + 1) tick();
    end
    checks++;
    if (high != TO) begin
      failures++;
      $display("FAIL timeout_strobe_len: write_q high %0d cycles, required %0d", high, TO);
    end
    tick();
    // dn on the expiry edge itself is a success
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h2100, 32'h0);
    tick();
    req_read = '0;
    for (int c = 0; c < TO - 1; c++) tick();
    read_dn = 1'b1;
    data_in = 32'hCAFEF00D;
    tick();
    read_dn = 1'b0;
    checks++;
    if ({done, err, read_q} !== {4'b0010, 1'b0, 1'b0} || rdata !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL timeout_dn_at_expiry: done=%b err=%b rq=%b rdata=%h, required 0010/0/0/cafef00d",
               done, err, read_q, rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    apply_reset();
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h500, 32'h0);
    tick();
    req_read = '0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({gnt, done, err, read_q, write_q, bus_busy} !== '0 || addr_out !== '0 || data_out !== '0) begin
      failures++;
      $display("FAIL midbusy_reset: gnt=%b done=%b err=%b rq=%b wq=%b busy=%b addr=%h, required 0",
               gnt, done, err, read_q, write_q, bus_busy, addr_out);
    end
    read_dn = 1'b1;
    tick();
    read_dn = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (done !== '0 || gnt !== '0) begin
      failures++;
      $display("FAIL midbusy_no_done: done=%b gnt=%b, required 0000/0000", done, gnt);
    end
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h600, 32'h0);
    set_req(3, 1'b1, 1'b0, 1'b0, 32'h700, 32'h0);
    tick();
    checks++;
    if (gnt !== 4'b0001 || addr_out !== 32'h600) begin
      failures++;
      $display("FAIL midbusy_ptr_cleared: gnt=%b addr=%h, required 0001/600", gnt, addr_out);
    end
    req_read = '0;
    read_dn = 1'b1;
    tick();
    read_dn = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0]  rd, wr, eg;
    logic [AW-1:0] a[N];
    logic [DW-1:0] d[N];
    logic [DW-1:0] din;
    logic          exp_wr;
    int            w, c, lat;
    apply_reset();
    for (int i = 0; i < N; i++) begin
      rd[i] = ($urandom_range(0, 1) == 1);
      wr[i] = ($urandom_range(0, 2) == 0);
      a[i]  = $urandom;
      d[i]  = $urandom;
    end
    for (int t = 0; t < 40; t++) begin
      if ((rd | wr) == '0) rd[$urandom_range(0, N - 1)] = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, rd[i], wr[i], 1'b0, a[i], d[i]);
      w = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (w < 0 && (rd[c] | wr[c])) w = c;
      end
      exp_wr = wr[w];
      eg = '0;
      eg[w] = 1'b1;
      tick();
      m_rr = (w + 1) % N;
      checks++;
      if ({gnt, read_q, write_q, bus_busy} !== {eg, ~exp_wr, exp_wr, 1'b1} || addr_out !== a[w] ||
          data_out !== (exp_wr ? d[w] : '0)) begin
        failures++;
        $display("FAIL random_grant[%0d]: gnt=%b rq=%b wq=%b addr=%h data=%h, required %b/%b/%b/%h/%h",
                 t, gnt, read_q, write_q, addr_out, data_out, eg, ~exp_wr, exp_wr, a[w],
                 exp_wr ? d[w] : '0);
      end
      lat = $urandom_range(0, 3);
      for (int j = 0; j < lat; j++) begin
        req_addr[w*AW +: AW] = $urandom;
        if (exp_wr) read_dn = $urandom_range(0, 1) == 1;
        else        write_dn = $urandom_range(0, 1) == 1;
        tick();
        checks++;
        if ({read_q, write_q, done} !== {~exp_wr, exp_wr, 4'b0000} || addr_out !== a[w]) begin
          failures++;
          $display("FAIL random_hold[%0d]: rq=%b wq=%b done=%b addr=%h, required %b/%b/0000/%h",
                   t, read_q, write_q, done, addr_out, ~exp_wr, exp_wr, a[w]);
        end
      end
      din = $urandom;
      data_in = din;
      read_dn = ~exp_wr;
      write_dn = exp_wr;
      tick();
      read_dn = 1'b0;
      write_dn = 1'b0;
      if (!exp_wr) m_rdata = din;
      checks++;
      if ({done, err, read_q, write_q} !== {eg, 1'b0, 1'b0, 1'b0} || rdata !== m_rdata) begin
        failures++;
        $display("FAIL random_done[%0d]: done=%b err=%b rq=%b wq=%b rdata=%h, required %b/0/0/0/%h",
                 t, done, err, read_q, write_q, rdata, eg, m_rdata);
      end
      rd[w] = ($urandom_range(0, 1) == 1);
      wr[w] = ($urandom_range(0, 2) == 0);
      a[w]  = $urandom;
      d[w]  = $urandom;
      set_req(w, rd[w], wr[w], 1'b0, a[w], d[w]);
      tick();
      checks++;
      if ({gnt, done, bus_busy} !== '0) begin
        failures++;
        $display("FAIL random_release[%0d]: gnt=%b done=%b busy=%b, required 0", t, gnt, done, bus_busy);
      end
    end
    req_read = '0;
    req_write = '0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_fairness();
    test_lock();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
